// File: rtl/twf2_1_cmul.sv
// 16-lane complex twiddle multiplier: 3-stage pipeline (capture, full-precision
// product, round/saturate) with group numbering for the external twiddle ROM.

module twf2_1_cmul_lane #(
  parameter int DW   = 13,
  parameter int FRAC = 8,
  parameter int TW   = 10
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 i_en1,
  input  logic                 i_en2,
  input  logic                 i_en3,
  input  logic signed [DW-1:0] i_re,
  input  logic signed [DW-1:0] i_im,
  input  logic signed [TW-1:0] i_tw_re,
  input  logic signed [TW-1:0] i_tw_im,
  output logic signed [DW-1:0] o_re,
  output logic signed [DW-1:0] o_im,
  output logic                 o_sat
);
  localparam int PW = DW + TW + 1;
  localparam logic signed [PW:0] RND  = (PW+1)'(2**(FRAC-1));
  localparam logic signed [PW:0] SMAX = (PW+1)'(2**(DW-1)-1);
  localparam logic signed [PW:0] SMIN = (PW+1)'(-(2**(DW-1)));

  logic signed [DW-1:0] r_a, r_b;
  logic signed [PW-1:0] r_pre, r_pim;
  logic signed [PW-1:0] w_a, w_b, w_c, w_d, w_pre, w_pim;
  logic signed [PW:0]   w_sre, w_sim;

  function automatic logic signed [DW-1:0] sat(input logic signed [PW:0] v);
    if (v > SMAX)      return {1'b0, {(DW-1){1'b1}}};
    else if (v < SMIN) return {1'b1, {(DW-1){1'b0}}};
    else               return v[DW-1:0];
  endfunction

  // Operands widened to the product width so the sum/difference cannot wrap.
  assign w_a   = PW'(r_a);
  assign w_b   = PW'(r_b);
  assign w_c   = PW'(i_tw_re);
  assign w_d   = PW'(i_tw_im);
  assign w_pre = w_a * w_c - w_b * w_d;
  assign w_pim = w_a * w_d + w_b * w_c;

  // Round half-up, then arithmetic shift (floor) keeps the half-up behaviour for negatives.
  assign w_sre = ((PW+1)'(r_pre) + RND) >>> FRAC;
  assign w_sim = ((PW+1)'(r_pim) + RND) >>> FRAC;
  assign o_sat = (w_sre > SMAX) || (w_sre < SMIN) || (w_sim > SMAX) || (w_sim < SMIN);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_a   <= '0;
      r_b   <= '0;
      r_pre <= '0;
      r_pim <= '0;
      o_re  <= '0;
      o_im  <= '0;
    end else begin
      if (i_en1) begin
        r_a <= i_re;
        r_b <= i_im;
      end
      if (i_en2) begin
        r_pre <= w_pre;
        r_pim <= w_pim;
      end
      if (i_en3) begin
        o_re <= sat(w_sre);
        o_im <= sat(w_sim);
      end
    end
  end
endmodule

module twf2_1_cmul #(
  parameter int DW   = 13,
  parameter int FRAC = 8
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 din_valid,
  input  logic                 din_sof,
  input  logic [15:0][DW-1:0]  din_re,
  input  logic [15:0][DW-1:0]  din_im,
  output logic [4:0]           grp_idx,
  input  logic [15:0][9:0]     tw_re,
  input  logic [15:0][9:0]     tw_im,
  output logic                 dout_valid,
  output logic                 dout_sof,
  output logic                 dout_eof,
  output logic [15:0][DW-1:0]  dout_re,
  output logic [15:0][DW-1:0]  dout_im,
  output logic                 dout_ovf
);
  localparam int NL     = 16;
  localparam int TW     = 10;
  localparam int STAGES = 3;

  logic [4:0]        r_grp_cnt;
  logic [STAGES:1]   r_vld, r_sof, r_eof;
  logic              r_ovf;
  logic [STAGES:0]   w_vld_pipe;
  logic [NL-1:0]     w_sat;

  assign grp_idx    = din_sof ? 5'd0 : r_grp_cnt;
  assign w_vld_pipe = {r_vld, din_valid};

  // Counter wraps naturally at 5 bits: group 31 is followed by group 0.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)          r_grp_cnt <= '0;
    else if (din_valid) r_grp_cnt <= grp_idx + 5'd1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_vld <= '0;
      r_sof <= '0;
      r_eof <= '0;
      r_ovf <= 1'b0;
    end else begin
      r_vld <= w_vld_pipe[STAGES-1:0];
      if (din_valid) begin
        r_sof[1] <= din_sof;
        r_eof[1] <= (grp_idx == 5'd31);
      end
      for (int k = 2; k <= STAGES; k++) begin
        if (w_vld_pipe[k-1]) begin
          r_sof[k] <= r_sof[k-1];
          r_eof[k] <= r_eof[k-1];
        end
      end
      if (w_vld_pipe[2]) r_ovf <= |w_sat;
    end
  end

  assign dout_valid = r_vld[STAGES];
  assign dout_sof   = r_sof[STAGES];
  assign dout_eof   = r_eof[STAGES];
  assign dout_ovf   = r_ovf;

  for (genvar l = 0; l < NL; l++) begin : g_lane
    twf2_1_cmul_lane #(.DW(DW), .FRAC(FRAC), .TW(TW)) u_lane (
      .clk     (clk),
      .rstn    (rstn),
      .i_en1   (w_vld_pipe[0]),
      .i_en2   (w_vld_pipe[1]),
      .i_en3   (w_vld_pipe[2]),
      .i_re    (din_re[l]),
      .i_im    (din_im[l]),
      .i_tw_re (tw_re[l]),
      .i_tw_im (tw_im[l]),
      .o_re    (dout_re[l]),
      .o_im    (dout_im[l]),
      .o_sat   (w_sat[l])
    );
  end
endmodule

// File: tb/tb_twf2_1_cmul.sv
// Directed bench for twf2_1_cmul: table of complex products plus framing,
// gap and reset sequences. Twiddle ROM modelled as a one-cycle delayed bus.
module tb_twf2_1_cmul;
  localparam int DW = 13, FRAC = 8, NL = 16, NV = 10;

  typedef struct {
    int are, aim, cre, cim, ere, eim;
    bit eovf;
  } vec_t;

  logic clk = 1'b0, rstn = 1'b0, din_valid = 1'b0, din_sof = 1'b0;
  logic [NL-1:0][DW-1:0] din_re = '0, din_im = '0, dout_re, dout_im;
  logic [NL-1:0][9:0] tw_re = '0, tw_im = '0, nxt_re = '0, nxt_im = '0;
  logic [4:0] grp_idx;
  logic dout_valid, dout_sof, dout_eof, dout_ovf;
  int checks = 0, failures = 0;
  int gq[$];

  always #5 clk = ~clk;

  twf2_1_cmul #(.DW(DW), .FRAC(FRAC)) dut (
    .clk(clk), .rstn(rstn), .din_valid(din_valid), .din_sof(din_sof),
    .din_re(din_re), .din_im(din_im), .grp_idx(grp_idx),
    .tw_re(tw_re), .tw_im(tw_im), .dout_valid(dout_valid),
    .dout_sof(dout_sof), .dout_eof(dout_eof), .dout_re(dout_re),
    .dout_im(dout_im), .dout_ovf(dout_ovf)
  );

  function automatic int sx(input logic [DW-1:0] v);
    return int'($signed(v));
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  // Any lane that disagrees is reported in place of the expected value.
  task automatic chk_blk(input string nm, input int ere, input int eim);
    int are = ere, aim = eim;
    for (int l = 0; l < NL; l++) begin
      if (sx(dout_re[l]) != ere) are = sx(dout_re[l]);
      if (sx(dout_im[l]) != eim) aim = sx(dout_im[l]);
    end
    chk({nm, "_re"}, are, ere);
    chk({nm, "_im"}, aim, eim);
  endtask

  task automatic drive(input bit v, input bit s, input int are, input int aim,
                       input int cre, input int cim);
    din_valid = v;
    din_sof   = s;
    for (int l = 0; l < NL; l++) begin
      din_re[l] = are[DW-1:0];
      din_im[l] = aim[DW-1:0];
      nxt_re[l] = cre[9:0];
      nxt_im[l] = cim[9:0];
    end
  endtask

  // One clock: log grp_idx of accepted blocks, then present the ROM result.
  task automatic tick();
    #1;
    if (din_valid && rstn) gq.push_back(int'(grp_idx));
    @(posedge clk);
    #1;
    tw_re = nxt_re;
    tw_im = nxt_im;
  endtask

  initial begin
    vec_t vt[NV];
    int pb[5];
    int oidx, neof, nstale;
    vt[0] = '{100, 50, 256, 0, 100, 50, 1'b0};
    vt[1] = '{100, 50, 0, -256, 50, -100, 1'b0};
    vt[2] = '{1, 0, 128, 0, 1, 0, 1'b0};
    vt[3] = '{-1, 0, 128, 0, 0, 0, 1'b0};
    vt[4] = '{4095, 4095, 181, 181, 0, 4095, 1'b1};
    vt[5] = '{1000, -300, 77, -33, 262, -219, 1'b0};
    vt[6] = '{-4096, -4096, 256, 256, 0, -4096, 1'b1};
    vt[7] = '{-4096, 0, 256, 0, -4096, 0, 1'b0};
    vt[8] = '{-129, 128, 1, 0, -1, 1, 1'b0};
    vt[9] = '{4095, 0, 257, 0, 4095, 0, 1'b1};
    pb = '{1, 0, 0, 1, 1};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", int'(dout_valid), 0);
    chk("rst_ovf", int'(dout_ovf), 0);
    chk("rst_grp", int'(grp_idx), 0);
    chk_blk("rst_dat", 0, 0);
    rstn = 1'b1;

    // Product table, one block per cycle
    for (int i = 0; i < NV + 2; i++) begin
      if (i < NV) drive(1'b1, 1'b0, vt[i].are, vt[i].aim, vt[i].cre, vt[i].cim);
      else        drive(1'b0, 1'b0, 0, 0, 0, 0);
      tick();
      if (i == 1) chk("lat_early", int'(dout_valid), 0);
      if (i >= 2) begin
        chk($sformatf("vec%0d_vld", i-2), int'(dout_valid), 1);
        chk_blk($sformatf("vec%0d", i-2), vt[i-2].ere, vt[i-2].eim);
        chk($sformatf("vec%0d_ovf", i-2), int'(dout_ovf), int'(vt[i-2].eovf));
      end
    end
    tick();
    chk("hold_vld", int'(dout_valid), 0);
    chk_blk("hold_dat", vt[NV-1].ere, vt[NV-1].eim);

    // Full frame of 32 plus one wrap block
    gq.delete();
    oidx = 0;
    for (int i = 0; i < 36; i++) begin
      if (i < 33) drive(1'b1, i == 0, i, -i, 256, 0);
      else        drive(1'b0, 1'b0, 0, 0, 0, 0);
      tick();
      if (dout_valid) begin
        chk($sformatf("fr%0d_sof", oidx), int'(dout_sof), int'(oidx == 0));
        chk($sformatf("fr%0d_eof", oidx), int'(dout_eof), int'(oidx == 31));
        chk_blk($sformatf("fr%0d", oidx), oidx, -oidx);
        oidx++;
      end
    end
    chk("fr_nout", oidx, 33);
    chk("fr_ngrp", gq.size(), 33);
    for (int i = 0; i < gq.size() && i < 33; i++) chk($sformatf("fr_grp%0d", i), gq[i], i % 32);

    // Valid gaps
    gq.delete();
    for (int i = 0; i < 8; i++) begin
      if (i < 5) drive(pb[i] != 0, i == 0, 10 + i, 0, 256, 0);
      else       drive(1'b0, 1'b0, 0, 0, 0, 0);
      tick();
      if (i >= 2) begin
        chk($sformatf("gap%0d_vld", i-2), int'(dout_valid), pb[i-2]);
        if (pb[i-2] != 0) chk_blk($sformatf("gap%0d", i-2), 10 + i - 2, 0);
      end
    end
    chk("gap_ngrp", gq.size(), 3);
    for (int i = 0; i < gq.size() && i < 3; i++) chk($sformatf("gap_grp%0d", i), gq[i], i);

    // Mid-frame restart
    gq.delete();
    neof = 0;
    for (int i = 0; i < 8; i++) begin
      if (i < 5) drive(1'b1, i == 0 || i == 3, 20 + i, 1, 256, 0);
      else       drive(1'b0, 1'b0, 0, 0, 0, 0);
      tick();
      if (dout_valid && dout_eof) neof++;
    end
    chk("mid_neof", neof, 0);
    chk("mid_ngrp", gq.size(), 5);
    for (int i = 0; i < gq.size() && i < 5; i++) chk($sformatf("mid_grp%0d", i), gq[i], (i < 3) ? i : i - 3);

    // Reset with three blocks in flight
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, i == 0, 7, 7, 256, 0);
      tick();
    end
    drive(1'b0, 1'b0, 0, 0, 0, 0);
    chk("inflt_vld", int'(dout_valid), 1);
    #2 rstn = 1'b0;
    #1;
    chk("arst_vld", int'(dout_valid), 0);
    chk("arst_sof", int'(dout_sof), 0);
    chk("arst_grp", int'(grp_idx), 0);
    chk_blk("arst_dat", 0, 0);
    @(posedge clk);
    #1 rstn = 1'b1;
    nstale = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (dout_valid) nstale++;
    end
    chk("arst_stale", nstale, 0);
    gq.delete();
    drive(1'b1, 1'b0, 9, -9, 256, 0);
    tick();
    drive(1'b0, 1'b0, 0, 0, 0, 0);
    tick();
    chk("post_early", int'(dout_valid), 0);
    tick();
    chk("post_vld", int'(dout_valid), 1);
    chk_blk("post", 9, -9);
    chk("post_ngrp", gq.size(), 1);
    if (gq.size() > 0) chk("post_grp", gq[0], 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/twf2_1_cmul.md
TWF2_1_CMUL -- requirements
Module: twf2_1_cmul

Interface
REQ-001 SHALL have parameter DW, default 13, signed width of each data sample (input and output).
REQ-002 SHALL have parameter FRAC, default 8, fractional bits of the twiddle (256 = +1.0).
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port din_valid  input  1  a 16-lane block is present on din_re/din_im this cycle.
REQ-006 SHALL have port din_sof  input  1  block is the first of a frame; qualified by din_valid.
REQ-007 SHALL have ports din_re, din_im  input  16 x DW signed  lane samples 0..15.
REQ-008 SHALL have port grp_idx  output  5  twiddle group index driven to the twiddle ROM stage.
REQ-009 SHALL have ports tw_re, tw_im  input  16 x 10 signed  twiddles returned by the ROM stage, valid one cycle after grp_idx.
REQ-010 SHALL have port dout_valid  output  1  result block valid.
REQ-011 SHALL have ports dout_sof, dout_eof  output  1 each  first / last (group 31) block of frame, qualified by dout_valid.
REQ-012 SHALL have ports dout_re, dout_im  output  16 x DW signed  products per lane.
REQ-013 SHALL have port dout_ovf  output  1  at least one lane/component saturated in this block, qualified by dout_valid.

Function
REQ-014 SHALL keep a 5-bit group counter grp_cnt; combinational grp_idx = din_sof ? 0 : grp_cnt.
REQ-015 SHALL on each cycle with din_valid=1 load grp_cnt <= grp_idx + 1 (modulo 32, 31 wraps to 0); din_valid=0 leaves grp_cnt unchanged.
REQ-016 SHALL treat din_sof=1 with din_valid=0 as no-op.
REQ-017 Stage 1 (edge after din_valid): SHALL register din_re/din_im, sof, eof flag (grp_idx==31) and valid, aligned with tw_re/tw_im arriving from the ROM stage.
REQ-018 Stage 2: SHALL compute per lane P_re = a*c - b*d, P_im = a*d + b*c (a=data re, b=data im, c=tw re, d=tw im), full precision DW+10+1 bits, registered.
REQ-019 Stage 3: SHALL round half-up (add 2^(FRAC-1), arithmetic shift right FRAC) then saturate to [-2^(DW-1), 2^(DW-1)-1], registered to dout_re/dout_im.
REQ-020 SHALL assert dout_ovf when any of the 32 components saturated in that block.
REQ-021 Latency SHALL be exactly 3 clk cycles from din_valid sample edge to dout_valid; throughput one block per cycle, no backpressure.
REQ-022 Sideband (valid, sof, eof) SHALL travel with its block through all three stages; gaps in din_valid SHALL produce matching gaps in dout_valid.
REQ-023 Data registers SHALL update only when their stage valid is 1; dout_* SHALL hold last value while dout_valid=0.
REQ-024 din_sof mid-frame SHALL restart numbering at group 0 with no error indication; the truncated frame produces no dout_eof.

Reset
REQ-025 rstn=0 SHALL immediately clear grp_cnt, all stage valids, dout_valid, dout_sof, dout_eof, dout_ovf, dout_re, dout_im to 0.
REQ-026 Reset mid-operation SHALL discard all in-flight blocks; first din_valid after release uses grp_idx 0 unless counter already advanced.
REQ-027 grp_idx SHALL read 0 while rstn=0 and din_sof=0.

Verification
REQ-028 tw=256+j0 all lanes, din=100+j50 lane 0, valid at edge N -> dout lane0 = 100+j50, dout_valid=1 at edge N+3, dout_ovf=0.
REQ-029 tw=0-j256, din=100+j50 -> dout=50-j100; din=1+j0, tw=128+j0 -> dout=1+j0; din=-1+j0, tw=128+j0 -> dout=0+j0.
REQ-030 din=4095+j4095, tw=181+j181 -> dout=0+j4095, dout_ovf=1 in that block only.
REQ-031 33 consecutive valid blocks, din_sof on first -> grp_idx 0..31,0; dout_eof on 32nd output block; dout_sof on 1st and none after until next din_sof.
REQ-032 valid pattern 1,0,0,1,1 with sof on first -> grp_idx sampled 0,1,2; dout_valid pattern identical, delayed 3 cycles.
REQ-033 rstn pulsed low for one cycle with 3 blocks in flight -> dout_valid 0 immediately and no stale block emerges afterward; next sof block outputs grp_idx 0.
